regfile16_bypass: RTL and testbench
===================================

Name: regfile16_bypass

Overview:
- 16-entry × WIDTH-bit register file: the integer register store of the pipelined processor.
- Two combinational read ports feed the decode stage; one synchronous write port is driven by writeback.
- Each read port is built per bit from the team's 16:1 one-bit mux primitive (mux16_1), with a 4:16 write decoder and write-enabled storage rows.
- Optional same-cycle write-to-read bypass removes the writeback→decode hazard.

Parameters:
- WIDTH, 64, data width of each register and of every data port.
- BYPASS, 1, 1 = same-cycle write-through forwarding to read ports; 0 = reads return stored contents only.
- ZERO_REG, 15, index of the hardwired-zero register. Reads return 0; writes are discarded.

Ports:
- clk  input  1  single clock. All writes occur on its rising edge.
- reset_n  input  1  asynchronous, active-low reset. Clears every register.
- RegWrite  input  1  write enable, sampled at rising clk.
- WriteRegister  input  4  destination register index.
- WriteData  input  WIDTH  data to be written.
- ReadRegister1  input  4  read port 1 index.
- ReadRegister2  input  4  read port 2 index.
- ReadData1  output  WIDTH  read port 1 data (combinational).
- ReadData2  output  WIDTH  read port 2 data (combinational).

Behaviour:
- Clocking and reset:
  - One clock. reset_n is asynchronous and active-low: reset is applied immediately on reset_n falling, with no clk edge required.
  - While reset_n = 0, all 16 registers are 0, so ReadData1 = ReadData2 = 0 for every index, including during bypass.
  - Deassertion is synchronous to clk by convention. The first write is accepted on the first rising edge with reset_n = 1.
- Storage:
  - 16 rows of WIDTH D flip-flops.
  - Row k has enable = RegWrite & (WriteRegister == k) & (k != ZERO_REG). Disabled rows hold their value.
  - Write latency: data is visible from storage 1 cycle after the rising edge.
- Write decoder: one-hot 4:16, gated by RegWrite. At most one row is enabled per cycle.
- Read datapath:
  - Per bit b, mux16_1 selects bit b of rows 0..15 with sel = ReadRegisterN.
  - Purely combinational: zero-cycle latency from index change to data.
- Zero register:
  - Row ZERO_REG never loads.
  - The read returns all-zero regardless of stored contents or bypass.
- Bypass (BYPASS = 1):
  - If RegWrite = 1, WriteRegister == ReadRegisterN, and ReadRegisterN != ZERO_REG, then ReadDataN = WriteData in the same cycle, before the edge.
  - Otherwise ReadDataN is the stored row.
  - Each port is evaluated independently. Both ports may bypass simultaneously when they read the same register.
- Bypass disabled (BYPASS = 0): reads return the stored row only. The new value appears the cycle after the edge.
- Boundary conditions:
  - RegWrite = 0 with any WriteRegister: no state change, no bypass.
  - WriteRegister = ZERO_REG with RegWrite = 1: no state change, and ReadDataN for index ZERO_REG is still 0.
  - Simultaneous read and write of the same index with BYPASS = 1: the read returns the new data. After the edge, storage holds the same data, so the output is continuous.
  - reset_n asserted mid-cycle while RegWrite = 1: the reset wins. The pending write is lost, and the registers stay 0 until the first edge after deassertion.
  - X or Z on an index input is not legal stimulus. Behaviour is undefined.

Test Plan:
- Reset: drive reset_n = 0 with no clk edges and sweep ReadRegister1/2 over 0..15 → every read returns 0. Release reset → all reads are still 0.
- Write/readback: for k = 0..14, write WriteData = 64'h1111_0000_0000_0000 + k (one write per cycle). Then read all pairs → ReadData1 = ReadData2 = the stored pattern; index 15 reads 0.
- Zero register: RegWrite = 1, WriteRegister = 15, WriteData = 64'hFFFF_FFFF_FFFF_FFFF; after the edge, read 15 on both ports → 0, and no other row has changed.
- Bypass (BYPASS = 1): reg 3 holds 64'hA; in one cycle drive RegWrite = 1, WriteRegister = 3, WriteData = 64'hDEAD_BEEF, ReadRegister1 = 3, ReadRegister2 = 4:
  - Before the edge: ReadData1 = 64'hDEAD_BEEF, ReadData2 = old reg 4.
  - After the edge with RegWrite = 0: ReadData1 = 64'hDEAD_BEEF.
- No bypass (BYPASS = 0), same stimulus: ReadData1 = 64'hA before the edge and 64'hDEAD_BEEF after.
- Reset mid-operation: write 64'h5 to reg 7, then pulse reset_n low for 3 ns between clk edges while RegWrite = 1, WriteRegister = 7, WriteData = 64'h9:
  - Reg 7 reads 0 immediately.
  - Reg 7 still reads 0 after the next edge if reset_n is still low at that edge.

Source files
------------

// File: rtl/regfile16_bypass_if.sv
// Register file access bundle: write port from writeback,
// two read ports toward decode.
interface regfile16_bypass_if #(
  parameter int WIDTH = 64
);
  logic             RegWrite;
  logic [3:0]       WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic [3:0]       ReadRegister1;
  logic [3:0]       ReadRegister2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData,
    output ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData,
    input  ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/regfile16_bypass.sv
// 16 x WIDTH integer register file, two combinational reads,
// one synchronous write, optional write-to-read bypass.
module mux16_1 (
  input  logic [15:0] d,
  input  logic [3:0]  sel,
  output logic        y
);
  assign y = d[sel];
endmodule

module regfile16_bypass #(
  parameter int WIDTH    = 64,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 15
) (
  input  logic           clk,
  input  logic           reset_n,
  regfile16_bypass_if.slave rf
);
  localparam logic [3:0] ZR = 4'(ZERO_REG);

  logic [WIDTH-1:0]       regs_q [16];
  logic [WIDTH-1:0]       regs_d [16];
  logic [15:0]            wr_en;
  logic [WIDTH-1:0][15:0] col;
  logic [WIDTH-1:0]       mux1;
  logic [WIDTH-1:0]       mux2;
  logic [WIDTH-1:0]       rd1;
  logic [WIDTH-1:0]       rd2;
  logic                   byp1;
  logic                   byp2;

  always_comb begin
    wr_en = '0;
    for (int k = 0; k < 16; k++) begin
      wr_en[k] = rf.RegWrite
               && (rf.WriteRegister == 4'(k))
               && (4'(k) != ZR);
      regs_d[k] = wr_en[k] ? rf.WriteData : regs_q[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 16; k++)
        regs_q[k] <= '0;
    end else begin
      for (int k = 0; k < 16; k++)
        regs_q[k] <= regs_d[k];
    end
  end

  // Bit-slice the rows so each bit gets its own 16:1 mux.
  always_comb begin
    col = '0;
    for (int b = 0; b < WIDTH; b++)
      for (int k = 0; k < 16; k++)
        col[b][k] = regs_q[k][b];
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    mux16_1 u_m1 (
      .d   (col[b]),
      .sel (rf.ReadRegister1),
      .y   (mux1[b])
    );
    mux16_1 u_m2 (
      .d   (col[b]),
      .sel (rf.ReadRegister2),
      .y   (mux2[b])
    );
  end

  always_comb begin
    byp1 = (BYPASS != 0) && rf.RegWrite
         && (rf.WriteRegister == rf.ReadRegister1);
    byp2 = (BYPASS != 0) && rf.RegWrite
         && (rf.WriteRegister == rf.ReadRegister2);
    rd1 = byp1 ? rf.WriteData : mux1;
    rd2 = byp2 ? rf.WriteData : mux2;
    // Reset also masks the bypass path.
    if (!reset_n || rf.ReadRegister1 == ZR)
      rd1 = '0;
    if (!reset_n || rf.ReadRegister2 == ZR)
      rd2 = '0;
  end

  assign rf.ReadData1 = rd1;
  assign rf.ReadData2 = rd2;
endmodule

// File: tb/tb_regfile16_bypass.sv
// Directed bench: one bypassing and one non-bypassing
// instance driven with identical stimulus.
module tb_regfile16_bypass;
  localparam int W = 64;

  typedef struct {
    logic [3:0]   r1;
    logic [3:0]   r2;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
  } vec_t;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t vecs [16];

  regfile16_bypass_if #(.WIDTH(W)) bif ();
  regfile16_bypass_if #(.WIDTH(W)) nif ();

  regfile16_bypass #(.WIDTH(W), .BYPASS(1), .ZERO_REG(15)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .rf      (bif.slave)
  );

  regfile16_bypass #(.WIDTH(W), .BYPASS(0), .ZERO_REG(15)) dut_n (
    .clk     (clk),
    .reset_n (reset_n),
    .rf      (nif.slave)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  function automatic logic [W-1:0] pat(input int k);
    if (k == 15) return '0;
    return 64'h1111_0000_0000_0000 + 64'(k);
  endfunction

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic rw, input logic [3:0] wr,
                     input logic [W-1:0] wd,
                     input logic [3:0] r1, input logic [3:0] r2);
    bif.RegWrite = rw;
    bif.WriteRegister = wr;
    bif.WriteData = wd;
    bif.ReadRegister1 = r1;
    bif.ReadRegister2 = r2;
    nif.RegWrite = rw;
    nif.WriteRegister = wr;
    nif.WriteData = wd;
    nif.ReadRegister1 = r1;
    nif.ReadRegister2 = r2;
  endtask

  task automatic chk4(input string nm,
                      input logic [W-1:0] e1,
                      input logic [W-1:0] e2);
    chk({nm, "_b1"}, bif.ReadData1, e1);
    chk({nm, "_b2"}, bif.ReadData2, e2);
    chk({nm, "_n1"}, nif.ReadData1, e1);
    chk({nm, "_n2"}, nif.ReadData2, e2);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      vecs[k].r1 = 4'(k);
      vecs[k].r2 = 4'(15 - k);
      vecs[k].e1 = pat(k);
      vecs[k].e2 = pat(15 - k);
    end

    // Reset held, clock stopped; a live write must not bypass.
    drv(1'b1, 4'd2, 64'h77, 4'd0, 4'd0);
    #2;
    for (int k = 0; k < 16; k++) begin
      drv(1'b1, 4'(k), 64'h77, 4'(k), 4'(15 - k));
      #1;
      chk4("rst_sweep", '0, '0);
    end
    drv(1'b0, 4'd0, '0, 4'd0, 4'd0);
    clk_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk4("rst_rel", '0, '0);
    @(negedge clk);
    #1;
    chk4("rst_rel_clk", '0, '0);

    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      drv(1'b1, 4'(k), pat(k), 4'd0, 4'd0);
    end
    @(negedge clk);
    drv(1'b0, 4'd0, '0, 4'd0, 4'd0);

    for (int i = 0; i < 16; i++) begin
      drv(1'b0, 4'd0, '0, vecs[i].r1, vecs[i].r2);
      #1;
      chk4("readback", vecs[i].e1, vecs[i].e2);
    end

    @(negedge clk);
    drv(1'b1, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 4'd15, 4'd15);
    #1;
    chk4("zero_pre", '0, '0);
    @(negedge clk);
    drv(1'b0, 4'd0, '0, 4'd15, 4'd15);
    #1;
    chk4("zero_post", '0, '0);
    for (int i = 0; i < 16; i++) begin
      drv(1'b0, 4'd0, '0, vecs[i].r1, vecs[i].r2);
      #1;
      chk4("zero_others", vecs[i].e1, vecs[i].e2);
    end

    @(negedge clk);
    drv(1'b1, 4'd3, 64'hA, 4'd0, 4'd0);
    @(negedge clk);
    drv(1'b1, 4'd3, 64'hDEAD_BEEF, 4'd3, 4'd4);
    #1;
    chk("byp_pre_b1", bif.ReadData1, 64'hDEAD_BEEF);
    chk("byp_pre_b2", bif.ReadData2, pat(4));
    chk("nbyp_pre_n1", nif.ReadData1, 64'hA);
    chk("nbyp_pre_n2", nif.ReadData2, pat(4));
    @(negedge clk);
    drv(1'b0, 4'd3, 64'h1234, 4'd3, 4'd4);
    #1;
    chk4("byp_post", 64'hDEAD_BEEF, pat(4));

    drv(1'b1, 4'd6, 64'h66, 4'd6, 4'd6);
    #1;
    chk("byp_both_b1", bif.ReadData1, 64'h66);
    chk("byp_both_b2", bif.ReadData2, 64'h66);
    chk("byp_both_n1", nif.ReadData1, pat(6));
    @(negedge clk);
    drv(1'b0, 4'd5, 64'h55, 4'd5, 4'd6);
    #1;
    chk4("noen_nobyp", pat(5), 64'h66);
    @(negedge clk);
    #1;
    chk4("noen_hold", pat(5), 64'h66);

    @(negedge clk);
    drv(1'b1, 4'd7, 64'h5, 4'd7, 4'd7);
    @(negedge clk);
    drv(1'b0, 4'd7, '0, 4'd7, 4'd7);
    #1;
    chk4("r7_set", 64'h5, 64'h5);
    drv(1'b1, 4'd7, 64'h9, 4'd7, 4'd7);
    reset_n = 1'b0;
    #1;
    chk4("mid_rst_now", '0, '0);
    #2;
    drv(1'b0, 4'd7, '0, 4'd7, 4'd7);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk4("mid_rst_edge", '0, '0);

    @(negedge clk);
    drv(1'b1, 4'd7, 64'h9, 4'd7, 4'd3);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk4("rst_over_edge", '0, '0);
    @(negedge clk);
    drv(1'b0, 4'd7, '0, 4'd7, 4'd3);
    reset_n = 1'b1;
    #1;
    chk4("rst_rel2", '0, '0);
    @(negedge clk);
    drv(1'b1, 4'd7, 64'h9, 4'd7, 4'd3);
    @(negedge clk);
    drv(1'b0, 4'd7, '0, 4'd7, 4'd3);
    #1;
    chk4("first_wr", 64'h9, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
